mem_access_unit: RTL and testbench

Load/store front end for `data_memory`, between the processor's memory stage and the word-only, 1024×32 `data_memory` array. It accepts byte-addressed load/store requests of byte, halfword or word size, and drives `data_memory`'s `ADDRESS`/`DATA`/`WE` pins. It performs read-modify-write for sub-word stores and aligns and extends load data. Misaligned or reserved-size requests are rejected without touching memory.

---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/byte_lane_unit.sv | 45 ++++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the data_memory load/store front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Request is rejected when the access straddles its natural alignment or uses the reserved size.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = |lane;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Lane extraction/extension for loads and read-modify-write merge for sub-word stores.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [31:0] sh_byte;
  logic [31:0] sh_half;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load path: shift the addressed lane down to bit 0, then zero- or sign-extend.
  always_comb begin
    sh_byte = word >> {lane, 3'b000};
    sh_half = word >> {lane[1], 4'b0000};
    ld_byte = sh_byte[7:0];
    ld_half = sh_half[15:0];
    ld_data = word;
    case (size)
      SIZE_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
      default:   ld_data = word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word read back from memory.
  always_comb begin
    st_data = word;
    case (size)
      SIZE_BYTE: st_data[{lane, 3'b000} +: 8]     = wdata[7:0];
      SIZE_HALF: st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:   st_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end driving a word-only synchronous data_memory.
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE (one request in flight); responses cannot be stalled.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                req_err;

  logic [31:0]         ld_data;
  logic [31:0]         st_data;

  byte_lane_unit u_lane (
    .word     (mem_q),
    .wdata    (wdata_q),
    .lane     (lane_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  // Next-state and datapath updates; everything holds unless a state explicitly changes it.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    sign_d        = sign_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    req_err       = req_misaligned(req_size, req_addr[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          size_d       = req_size;
          sign_d       = req_signed;
          lane_d       = req_addr[1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_error_d = req_err;
          if (req_err) begin
            // Rejected requests never move the memory address or data pins.
            state_d = ST_RESP;
          end else begin
            mem_address_d = req_addr[ADDR_W+1:2];
            if (req_write && req_size == SIZE_WORD) begin
              // Full-word store needs no read-back; data goes straight to WR.
              mem_data_d = req_wdata;
              state_d    = ST_WR;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        if (write_q) begin
          mem_data_d = st_data;
          state_d    = ST_WR;
        end else begin
          resp_rdata_d = ld_data;
          state_d      = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      size_q        <= SIZE_BYTE;
      sign_q        <= 1'b0;
      lane_q        <= '0;
      wdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
    end
  end

  // Write enable is gated by RESET directly so an abort during WR never commits a partial write.
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    resp_valid  = (state_q == ST_RESP);
    mem_we      = (state_q == ST_WR) & ~RESET;
    mem_address = mem_address_q;
    mem_data    = mem_data_q;
    resp_rdata  = resp_rdata_q;
    resp_error  = resp_error_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_q;

  mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 CLK = ~CLK;

  // data_memory stand-in: 1024x32, registered Q, write on WE.
  logic [31:0] mem [1024];
  logic        init_mem = 1'b1;
  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem_q <= 32'h0;
    end else begin
      if (mem_we) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_address];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic        we_exp;
    logic [9:0]  waddr;
  } exp_t;
  exp_t sbq[$];

  // Byte-addressed reference memory.
  logic [7:0] ref_b [4096];

  function automatic exp_t model(input bit w, input bit [1:0] sz, input bit sg,
                                 input bit [11:0] a, input bit [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] val;
    n = 1 << sz;
    e.err = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    e.rdata = 32'h0;
    e.waddr = a[11:2];
    e.we_exp = !e.err && w;
    e.acc = 0;
    if (e.err) e.lat = 1;
    else if (w && sz == 2) e.lat = 2;
    else if (w) e.lat = 4;
    else e.lat = 3;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < n; k++) ref_b[int'(a) + k] = wd[8*k +: 8];
      end else begin
        val = 32'h0;
        for (int k = 0; k < n; k++) val[8*k +: 8] = ref_b[int'(a) + k];
        if (sg && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
        e.rdata = val;
      end
    end
    return e;
  endfunction

  // Monitor: pop and compare on every response; police write strobes.
  always begin
    @(negedge CLK);
    #1;
    if (RESET) begin
      chk("resp_valid_in_reset", {31'h0, resp_valid}, 32'h0);
      chk("mem_we_in_reset", {31'h0, mem_we}, 32'h0);
    end else begin
      if (mem_we) begin
        if (sbq.size() == 0 || !sbq[0].we_exp) begin
          chk("unexpected_mem_we", {31'h0, mem_we}, 32'h0);
        end else begin
          chk("wr_address", {22'h0, mem_address}, {22'h0, sbq[0].waddr});
        end
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", {31'h0, resp_error}, {31'h0, e.err});
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue(input bit w, input bit [1:0] sz, input bit sg, input bit [11:0] a,
                       input bit [31:0] wd, input bit track, input bit fixed,
                       input bit [31:0] fixed_rd, output int acc);
    int n;
    exp_t e;
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    acc = cyc;
    if (track) begin
      e = model(w, sz, sg, a, wd);
      if (fixed) e.rdata = fixed_rd;
      e.acc = acc;
      sbq.push_back(e);
    end
    @(negedge CLK);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr = 12'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("resp_timeout", sbq.size(), 0);
      sbq.delete();
    end
    #2;
  endtask

  task automatic req(input bit w, input bit [1:0] sz, input bit sg, input bit [11:0] a,
                     input bit [31:0] wd);
    int acc;
    issue(w, sz, sg, a, wd, 1'b1, 1'b0, 32'h0, acc);
    drain();
  endtask

  task automatic req_fixed(input bit w, input bit [1:0] sz, input bit sg, input bit [11:0] a,
                           input bit [31:0] wd, input bit [31:0] exp_rd);
    int acc;
    issue(w, sz, sg, a, wd, 1'b1, 1'b1, exp_rd, acc);
    drain();
  endtask

  initial begin
    int acc;
    int bad;
    for (int i = 0; i < 4096; i++) ref_b[i] = 8'h0;

    // Reset values.
    repeat (2) @(posedge CLK);
    init_mem = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_mem_address", {22'h0, mem_address}, 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    RESET = 1'b0;

    // Word store then word load.
    req_fixed(1, 2'd2, 0, 12'h010, 32'hDEADBEEF, 32'h0);
    chk("word_store_mem4", mem[4], 32'hDEADBEEF);
    req_fixed(0, 2'd2, 0, 12'h010, 32'h0, 32'hDEADBEEF);

    // Sub-word RMW store and byte loads.
    req(1, 2'd2, 0, 12'h010, 32'h11223344);
    req_fixed(1, 2'd0, 0, 12'h011, 32'hFFFF_FFAB, 32'h0);
    chk("byte_store_mem4", mem[4], 32'h1122AB44);
    req_fixed(0, 2'd0, 1, 12'h011, 32'h0, 32'hFFFFFFAB);
    req_fixed(0, 2'd0, 0, 12'h011, 32'h0, 32'h000000AB);

    // Halfword loads.
    req(1, 2'd2, 0, 12'h010, 32'h80017FFE);
    req_fixed(0, 2'd1, 1, 12'h012, 32'h0, 32'hFFFF8001);
    req_fixed(0, 2'd1, 0, 12'h010, 32'h0, 32'h00007FFE);
    req_fixed(0, 2'd1, 1, 12'h010, 32'h0, 32'h00007FFE);

    // Error cases (misaligned word, reserved size, misaligned half store).
    req_fixed(0, 2'd2, 0, 12'h013, 32'h0, 32'h0);
    req_fixed(0, 2'd3, 0, 12'h000, 32'h0, 32'h0);
    req_fixed(1, 2'd1, 0, 12'h011, 32'h0000_BEEF, 32'h0);
    chk("err_store_untouched", mem[4], 32'h80017FFE);

    // Highest byte address.
    req(1, 2'd2, 0, 12'hFFC, 32'h01234567);
    req(1, 2'd0, 0, 12'hFFF, 32'h0000005A);
    chk("top_byte_store", mem[1023], 32'h5A234567);
    req_fixed(0, 2'd0, 0, 12'hFFF, 32'h0, 32'h0000005A);

    // Reset held 2 cycles in the middle of a load.
    issue(0, 2'd2, 0, 12'hFFC, 32'h0, 1'b0, 1'b0, 32'h0, acc);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #2;
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_resp_rdata", resp_rdata, 32'h0);

    // Reset asserted during WR of a sub-word store.
    req(1, 2'd2, 0, 12'h020, 32'hCAFEF00D);
    issue(1, 2'd0, 0, 12'h021, 32'h77, 1'b0, 1'b0, 32'h0, acc);
    bad = 0;
    while (cyc != acc + 3 && bad < 20) begin
      @(negedge CLK);
      bad++;
    end
    RESET = 1'b1;
    #1;
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    #2;
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge CLK);
    chk("abort_word_unchanged", mem[8], 32'hCAFEF00D);
    chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);

    // Randomized traffic over a small low window and the top of memory.
    for (int t = 0; t < 300; t++) begin
      bit [11:0] a;
      bit [1:0]  sz;
      a = ($urandom_range(0, 3) == 0) ? 12'(12'hFE0 + $urandom_range(0, 31))
                                      : 12'($urandom_range(0, 63));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    // Whole-memory comparison against the reference bytes.
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) bad++;
    end
    chk("final_memory_words_wrong", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
